div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// Returns {remainder, quotient}. A zero divisor finishes early with div_zero_o set.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH:0]    work;
    logic [WIDTH-1:0]    divisor;
    logic                neg_quot;
    logic                neg_rem;

    logic [WIDTH-1:0]    op1_abs;
    logic [WIDTH-1:0]    op2_abs;
    logic [2*WIDTH:0]    shifted;
    logic [WIDTH:0]      trial;
    logic [WIDTH-1:0]    quot_fix;
    logic [WIDTH-1:0]    rem_fix;

    // work holds {partial remainder (WIDTH+1 bits), dividend/quotient (WIDTH bits)}
    always_comb begin
        op1_abs  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_abs  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted  = {work[2*WIDTH-1:0], 1'b0};
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
        quot_fix = neg_quot ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_fix  = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    end

    assign busy_o = (state == ON) || (state == BYZERO) ||
                    ((state == FREE) && start_i && !annul_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FREE;
            cnt        <= '0;
            work       <= '0;
            divisor    <= '0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
        end else if (annul_i && (state != FREE)) begin
            state      <= FREE;
            cnt        <= '0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
                        divisor  <= op2_abs;
                        work     <= {{(WIDTH+1){1'b0}}, op1_abs};
                        cnt      <= '0;
                        state    <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    result_o   <= '0;
                    div_zero_o <= 1'b1;
                    ready_o    <= 1'b1;
                    state      <= END;
                end
                ON: begin
                    if (cnt == CW'(WIDTH)) begin
                        result_o   <= {rem_fix, quot_fix};
                        ready_o    <= 1'b1;
                        div_zero_o <= 1'b0;
                        state      <= END;
                    end else begin
                        // Keep the trial subtraction only when it did not go negative
                        if (!trial[WIDTH]) begin
                            work <= {trial, shifted[WIDTH-1:1], 1'b1};
                        end else begin
                            work <= shifted;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state      <= FREE;
                        result_o   <= '0;
                        ready_o    <= 1'b0;
                        div_zero_o <= 1'b0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule
